blob_unit: RTL and testbench



---
 rtl/gpu_pkg.sv | 38 +++
 rtl/blob_cfg_regs.sv | 51 +++++
 rtl/blob_unit.sv | 116 +++++++++++
 tb/tb_blob_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the sprite (blob) request generators.
// Optional feature macro: BLOB_MIRROR_EN adds a horizontal-mirror bit per blob.
package gpu_pkg;

    localparam int ADD_WIDTH   = 16;
    localparam int COORD_WIDTH = 10;
    localparam int SIZE_WIDTH  = 8;

    typedef logic [1:0] layer_t;

    localparam logic [2:0] CFG_POS_X  = 3'd0;
    localparam logic [2:0] CFG_POS_Y  = 3'd1;
    localparam logic [2:0] CFG_WIDTH  = 3'd2;
    localparam logic [2:0] CFG_HEIGHT = 3'd3;
    localparam logic [2:0] CFG_BASE   = 3'd4;
    localparam logic [2:0] CFG_CTRL   = 3'd5;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] pos_x;
        logic [COORD_WIDTH-1:0] pos_y;
        logic [SIZE_WIDTH-1:0]  width;
        logic [SIZE_WIDTH-1:0]  height;
        logic [ADD_WIDTH-1:0]   base_addr;
        logic                   enable;
        layer_t                 layer;
`ifdef BLOB_MIRROR_EN
        logic                   mirror_x;
`endif
    } blob_cfg_t;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ABOVE  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } blob_state_t;

endpackage

// File: rtl/blob_cfg_regs.sv
// Pending/active sprite configuration pair; the active set only changes at frame_start.
// Optional feature macro: BLOB_MIRROR_EN (mirror_x bit in the control register).
module blob_cfg_regs
    import gpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_sel,
    input  logic [15:0] cfg_data,
    input  logic        frame_start,
    output blob_cfg_t   active_cfg,
    output logic        load_enable,
    output logic [ADD_WIDTH-1:0] load_base_addr
);

    blob_cfg_t pending_cfg;

    // Values the active set takes on at this frame_start.
    assign load_enable    = pending_cfg.enable;
    assign load_base_addr = pending_cfg.base_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_cfg <= '0;
            active_cfg  <= '0;
        end else begin
            // Transfer uses the old pending value, so a same-cycle write lands next frame.
            if (frame_start)
                active_cfg <= pending_cfg;
            if (cfg_wr) begin
                case (cfg_sel)
                    CFG_POS_X:  pending_cfg.pos_x     <= cfg_data[COORD_WIDTH-1:0];
                    CFG_POS_Y:  pending_cfg.pos_y     <= cfg_data[COORD_WIDTH-1:0];
                    CFG_WIDTH:  pending_cfg.width     <= cfg_data[SIZE_WIDTH-1:0];
                    CFG_HEIGHT: pending_cfg.height    <= cfg_data[SIZE_WIDTH-1:0];
                    CFG_BASE:   pending_cfg.base_addr <= cfg_data[ADD_WIDTH-1:0];
                    CFG_CTRL: begin
                        pending_cfg.enable <= cfg_data[2];
                        pending_cfg.layer  <= cfg_data[1:0];
`ifdef BLOB_MIRROR_EN
                        pending_cfg.mirror_x <= cfg_data[3];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/blob_unit.sv
// Per-sprite request generator: coverage compare, incremental address counter and raster FSM.
// Optional feature macro: BLOB_MIRROR_EN enables horizontally mirrored addressing.
module blob_unit
    import gpu_pkg::*;
#(
    parameter int ADD_WIDTH   = gpu_pkg::ADD_WIDTH,
    parameter int COORD_WIDTH = gpu_pkg::COORD_WIDTH,
    parameter int SIZE_WIDTH  = gpu_pkg::SIZE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_wr,
    input  logic [2:0]             cfg_sel,
    input  logic [15:0]            cfg_data,
    input  logic                   frame_start,
    input  logic                   pix_en,
    input  logic [COORD_WIDTH-1:0] pix_x,
    input  logic [COORD_WIDTH-1:0] pix_y,
    output logic                   request,
    output logic [ADD_WIDTH-1:0]   address,
    output logic [1:0]             layer
);

    blob_cfg_t               active_cfg;
    logic                    load_enable;
    logic [ADD_WIDTH-1:0]    load_base_addr;
    blob_state_t             state, state_nxt;
    logic [ADD_WIDTH-1:0]    row_base, row_base_nxt, address_nxt;
    logic                    request_nxt;

    blob_cfg_regs u_cfg (
        .clk            (clk),
        .reset          (reset),
        .cfg_wr         (cfg_wr),
        .cfg_sel        (cfg_sel),
        .cfg_data       (cfg_data),
        .frame_start    (frame_start),
        .active_cfg     (active_cfg),
        .load_enable    (load_enable),
        .load_base_addr (load_base_addr)
    );

    // Active base/enable are consumed via the pending side at frame_start.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{active_cfg.base_addr, active_cfg.enable};

    assign layer = active_cfg.layer;

    // Bounds in one extra bit so pos + size never wraps.
    logic [COORD_WIDTH:0]   x_last, y_last;
    logic                   in_x, in_y, covered, at_x_last, at_y_last, eval_pix;
    logic [COORD_WIDTH-1:0] dx;
    logic [ADD_WIDTH-1:0]   offset, width_ext;

    always_comb begin
        x_last    = {1'b0, active_cfg.pos_x} + (COORD_WIDTH+1)'(active_cfg.width) - 1'b1;
        y_last    = {1'b0, active_cfg.pos_y} + (COORD_WIDTH+1)'(active_cfg.height) - 1'b1;
        in_x      = (active_cfg.width != '0) && (pix_x >= active_cfg.pos_x)
                    && ({1'b0, pix_x} <= x_last);
        in_y      = (active_cfg.height != '0) && (pix_y >= active_cfg.pos_y)
                    && ({1'b0, pix_y} <= y_last);
        covered   = in_x && in_y;
        at_x_last = ({1'b0, pix_x} == x_last);
        at_y_last = ({1'b0, pix_y} == y_last);
        dx        = pix_x - active_cfg.pos_x;
        width_ext = ADD_WIDTH'(active_cfg.width);
`ifdef BLOB_MIRROR_EN
        offset    = active_cfg.mirror_x ? (width_ext - 1'b1 - ADD_WIDTH'(dx)) : ADD_WIDTH'(dx);
`else
        offset    = ADD_WIDTH'(dx);
`endif
        eval_pix  = pix_en && ((state == ST_ACTIVE) ||
                               ((state == ST_ABOVE) && (pix_y == active_cfg.pos_y)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_WAIT;
            request  <= 1'b0;
            address  <= '0;
            row_base <= '0;
        end else begin
            state    <= state_nxt;
            request  <= request_nxt;
            address  <= address_nxt;
            row_base <= row_base_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        request_nxt  = request;
        address_nxt  = address;
        row_base_nxt = row_base;
        if (frame_start) begin
            state_nxt    = load_enable ? ST_ABOVE : ST_WAIT;
            request_nxt  = 1'b0;
            row_base_nxt = load_base_addr;
        end else if (pix_en) begin
            request_nxt = 1'b0;
            if (eval_pix) begin
                state_nxt = ST_ACTIVE;
                if (covered) begin
                    request_nxt = 1'b1;
                    address_nxt = row_base + offset;
                    if (at_x_last) begin
                        row_base_nxt = row_base + width_ext;
                        if (at_y_last)
                            state_nxt = ST_DONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_blob_unit.sv
// Directed bench for blob_unit on a 32x10 raster, one pixel strobe every 4 clk.
module tb_blob_unit;

    localparam int SCR_W = 32;
    localparam int SCR_H = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_sel = '0;
    logic [15:0] cfg_data = '0;
    logic        frame_start = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        request;
    logic [15:0] address;
    logic [1:0]  layer;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_addr = '0;

    always #5 clk = ~clk;

    blob_unit dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_wr      (cfg_wr),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .frame_start (frame_start),
        .pix_en      (pix_en),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .request     (request),
        .address     (address),
        .layer       (layer)
    );

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic cfg_write(input int sel, input int data);
        @(posedge clk) #1;
        cfg_wr = 1'b1; cfg_sel = 3'(sel); cfg_data = 16'(data);
        @(posedge clk) #1;
        cfg_wr = 1'b0;
    endtask

    task automatic set_sprite(input int px, input int py, input int w, input int h,
                              input int base, input int ctrl);
        cfg_write(0, px); cfg_write(1, py); cfg_write(2, w);
        cfg_write(3, h);  cfg_write(4, base); cfg_write(5, ctrl);
    endtask

    task automatic pulse_frame_start();
        @(posedge clk) #1;
        frame_start = 1'b1;
        @(posedge clk) #1;
        frame_start = 1'b0;
    endtask

    // Strobe one pixel; outputs are valid on return (one edge after pix_en).
    task automatic pixel(input int x, input int y);
        @(posedge clk) #1;
        pix_x = 10'(x); pix_y = 10'(y); pix_en = 1'b1;
        @(posedge clk) #1;
        pix_en = 1'b0;
    endtask

    task automatic check_pixel(input string tag, input int x, input int y,
                               input bit exp_req, input int lay);
        vectors++;
        if (request !== exp_req) begin
            miscompares++;
            $display("FAIL %s request (%0d,%0d): got %0b exp %0b", tag, x, y, request, exp_req);
        end
        vectors++;
        if (address !== exp_addr) begin
            miscompares++;
            $display("FAIL %s address (%0d,%0d): got %h exp %h", tag, x, y, address, exp_addr);
        end
        vectors++;
        if (layer !== 2'(lay)) begin
            miscompares++;
            $display("FAIL %s layer (%0d,%0d): got %0d exp %0d", tag, x, y, layer, lay);
        end
    endtask

    // Full raster; expected addresses come from base + row*width + column.
    task automatic run_frame(input string tag, input int px, input int py, input int w,
                             input int h, input int base, input bit en, input int lay,
                             input bit mirror, input bit mid_wr);
        bit cov;
        pulse_frame_start();
        idle(1);
        for (int y = 0; y < SCR_H; y++) begin
            for (int x = 0; x < SCR_W; x++) begin
                pixel(x, y);
                cov = en && (w > 0) && (h > 0) && (x >= px) && (x < px + w)
                      && (y >= py) && (y < py + h);
                if (cov) begin
                    if (mirror)
                        exp_addr = 16'(base + (y - py) * w + (w - 1 - (x - px)));
                    else
                        exp_addr = 16'(base + (y - py) * w + (x - px));
                end
                check_pixel(tag, x, y, cov, lay);
                if (mid_wr && x == 0 && y == 3)
                    cfg_write(0, 20);
                else
                    idle(2);
            end
        end
    endtask

    task automatic test_reset();
        idle(3);
        @(posedge clk) #1;
        reset = 1'b0;
        idle(1);
        #1;
        exp_addr = '0;
        check_pixel("reset", 0, 0, 1'b0, 0);
    endtask

    task automatic test_basic();
        set_sprite(10, 5, 4, 2, 16'h0100, 3'b110);
        run_frame("basic", 10, 5, 4, 2, 16'h0100, 1'b1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_deferred();
        run_frame("deferred_cur", 10, 5, 4, 2, 16'h0100, 1'b1, 2, 1'b0, 1'b1);
        run_frame("deferred_next", 20, 5, 4, 2, 16'h0100, 1'b1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_zero_and_disable();
        cfg_write(0, 10);
        cfg_write(2, 0);
        run_frame("zero_width", 10, 5, 0, 2, 16'h0100, 1'b1, 2, 1'b0, 1'b0);
        cfg_write(2, 4);
        cfg_write(5, 3'b010);
        run_frame("disabled", 10, 5, 4, 2, 16'h0100, 1'b0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        set_sprite(10, 5, 4, 1, 16'hFFFE, 3'b101);
        run_frame("wrap", 10, 5, 4, 1, 16'hFFFE, 1'b1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_collision();
        set_sprite(0, 0, 4, 2, 16'h0200, 3'b111);
        pulse_frame_start();
        idle(1);
        @(posedge clk) #1;
        frame_start = 1'b1; pix_en = 1'b1; pix_x = 10'd0; pix_y = 10'd0;
        @(posedge clk) #1;
        frame_start = 1'b0; pix_en = 1'b0;
        check_pixel("collision", 0, 0, 1'b0, 3);
        idle(2);
        pixel(1, 0);
        exp_addr = 16'h0201;
        check_pixel("collision_next", 1, 0, 1'b1, 3);
        idle(2);
    endtask

    task automatic test_reset_mid();
        bit cov;
        bit after_rst;
        after_rst = 1'b0;
        set_sprite(10, 5, 4, 2, 16'h0100, 3'b110);
        pulse_frame_start();
        idle(1);
        for (int y = 0; y < SCR_H; y++) begin
            for (int x = 0; x < SCR_W; x++) begin
                if (x == 12 && y == 5) begin
                    @(posedge clk) #1;
                    reset = 1'b1;
                    @(posedge clk) #1;
                    reset = 1'b0;
                    after_rst = 1'b1;
                    exp_addr = '0;
                    check_pixel("reset_mid", x, y, 1'b0, 0);
                    idle(2);
                end else begin
                    pixel(x, y);
                    cov = !after_rst && (x >= 10) && (x < 14) && (y >= 5) && (y < 7);
                    if (cov)
                        exp_addr = 16'(16'h0100 + (y - 5) * 4 + (x - 10));
                    check_pixel("reset_mid", x, y, cov, after_rst ? 0 : 2);
                    idle(2);
                end
            end
        end
        run_frame("post_reset", 10, 5, 4, 2, 16'h0100, 1'b0, 0, 1'b0, 1'b0);
    endtask

`ifdef BLOB_MIRROR_EN
    task automatic test_mirror();
        set_sprite(10, 5, 4, 2, 16'h0100, 4'b1110);
        run_frame("mirror", 10, 5, 4, 2, 16'h0100, 1'b1, 2, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_deferred();
        test_zero_and_disable();
        test_wrap();
        test_collision();
`ifdef BLOB_MIRROR_EN
        test_mirror();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
